uart_rx_bit_timer: RTL and testbench

//  Parametrised bit/edge timing engine for the UART RX path. It counts oversampling

---
 rtl/uart_rx_bit_timer.sv | 125 ++++++++++++
 tb/tb_uart_rx_bit_timer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_bit_timer.sv
// Bit/edge timing engine for the UART RX path: counts oversampling edges per bit and bits per
// frame, decodes three mid-bit sample strobes and flags bit/frame boundaries.
module uart_rx_bit_timer #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4,
    parameter int MIN_PRESC  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Enable,
    input  logic                  Restart,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [BIT_CNT_W-1:0]  Frame_Bits,
    output logic [PRESCALE_W-1:0] edge_count,
    output logic [BIT_CNT_W-1:0]  bit_count,
    output logic                  samp_en,
    output logic [1:0]            samp_idx,
    output logic                  bit_tick,
    output logic                  frame_done,
    output logic                  prescale_err,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

    localparam logic [PRESCALE_W-1:0] MIN_P = PRESCALE_W'(MIN_PRESC);

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   p_q, p_d;
    logic [BIT_CNT_W-1:0]    f_q, f_d;
    logic [PRESCALE_W-1:0]   edge_d;
    logic [BIT_CNT_W-1:0]    bit_d;
    logic                    done_d;
    logic                    err_d;
    logic [PRESCALE_W-1:0]   mid;
    logic                    last_edge;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            p_q          <= '0;
            f_q          <= '0;
            edge_count   <= '0;
            bit_count    <= '0;
            frame_done   <= 1'b0;
            prescale_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            f_q          <= f_d;
            edge_count   <= edge_d;
            bit_count    <= bit_d;
            frame_done   <= done_d;
            prescale_err <= err_d;
        end
    end

    assign last_edge = (edge_count == p_q - 1'b1);

    // Priority: Enable low, then a (re)latch from Restart or IDLE, then normal counting.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        f_d     = f_q;
        edge_d  = edge_count;
        bit_d   = bit_count;
        done_d  = 1'b0;
        err_d   = prescale_err;
        if (!Enable) begin
            state_d = IDLE;
            edge_d  = '0;
            bit_d   = '0;
            err_d   = 1'b0;
        end else if (Restart || state_q == IDLE) begin
            edge_d = '0;
            bit_d  = '0;
            p_d    = Prescale;
            f_d    = Frame_Bits;
            if (Prescale >= MIN_P) begin
                state_d = RUN;
                err_d   = 1'b0;
            end else begin
                state_d = ERR;
                err_d   = 1'b1;
            end
        end else if (state_q == RUN) begin
            if (last_edge) begin
                edge_d = '0;
                if (bit_count == f_q - 1'b1) begin
                    bit_d   = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    bit_d = bit_count + 1'b1;
                end
            end else begin
                edge_d = edge_count + 1'b1;
            end
        end
    end

    // Sample strobes straddle mid-bit; odd prescales round mid down.
    assign mid = p_q >> 1;

    always_comb begin
        samp_en  = 1'b0;
        samp_idx = 2'd0;
        if (state_q == RUN) begin
            if (edge_count == mid - 1'b1) begin
                samp_en  = 1'b1;
                samp_idx = 2'd0;
            end else if (edge_count == mid) begin
                samp_en  = 1'b1;
                samp_idx = 2'd1;
            end else if (edge_count == mid + 1'b1) begin
                samp_en  = 1'b1;
                samp_idx = 2'd2;
            end
        end
    end

    assign bit_tick  = (state_q == RUN) && last_edge;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// Directed bench for uart_rx_bit_timer: expected counter/strobe values are derived from the
// cycle index since the frame was latched.
module tb_uart_rx_bit_timer;

    logic       CLK;
    logic       RST;
    logic       Enable;
    logic       Restart;
    logic [5:0] Prescale;
    logic [3:0] Frame_Bits;
    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic       samp_en;
    logic [1:0] samp_idx;
    logic       bit_tick;
    logic       frame_done;
    logic       prescale_err;
    logic [1:0] state_dbg;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_ERR = 2'd3;

    uart_rx_bit_timer #(.PRESCALE_W(6), .BIT_CNT_W(4), .MIN_PRESC(4)) dut (
        .CLK(CLK), .RST(RST), .Enable(Enable), .Restart(Restart),
        .Prescale(Prescale), .Frame_Bits(Frame_Bits),
        .edge_count(edge_count), .bit_count(bit_count), .samp_en(samp_en),
        .samp_idx(samp_idx), .bit_tick(bit_tick), .frame_done(frame_done),
        .prescale_err(prescale_err), .state_dbg(state_dbg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " edge"}, 32'(edge_count), 0);
        chk({tag, " bit"}, 32'(bit_count), 0);
        chk({tag, " samp_en"}, 32'(samp_en), 0);
        chk({tag, " bit_tick"}, 32'(bit_tick), 0);
        chk({tag, " frame_done"}, 32'(frame_done), 0);
    endtask

    // Checks cycles k0..k0+n-1 counted from the latch, ticking after each.
    task automatic run_bits(input int p, input int f, input int k0, input int n);
        int e, b, mid;
        for (int k = k0; k < k0 + n; k++) begin
            e   = k % p;
            b   = (k / p) % f;
            mid = p / 2;
            chk($sformatf("p%0d k%0d edge", p, k), 32'(edge_count), e);
            chk($sformatf("p%0d k%0d bit", p, k), 32'(bit_count), b);
            chk($sformatf("p%0d k%0d samp_en", p, k), 32'(samp_en),
                (e >= mid - 1 && e <= mid + 1) ? 1 : 0);
            if (e >= mid - 1 && e <= mid + 1)
                chk($sformatf("p%0d k%0d samp_idx", p, k), 32'(samp_idx), e - mid + 1);
            chk($sformatf("p%0d k%0d bit_tick", p, k), 32'(bit_tick), (e == p - 1) ? 1 : 0);
            chk($sformatf("p%0d k%0d frame_done", p, k), 32'(frame_done), 0);
            chk($sformatf("p%0d k%0d state", p, k), 32'(state_dbg), S_RUN);
            tick();
        end
    endtask

    initial begin
        RST = 1'b1; Enable = 1'b0; Restart = 1'b0; Prescale = 6'd8; Frame_Bits = 4'd10;
        #3 RST = 1'b0;
        tick(); tick();
        chk_quiet("reset");
        chk("reset err", 32'(prescale_err), 0);
        chk("reset state", 32'(state_dbg), S_IDLE);
        RST = 1'b1;
        tick();
        chk("idle state", 32'(state_dbg), S_IDLE);

        // P=8, F=10 full frame
        Enable = 1'b1;
        tick();
        run_bits(8, 10, 0, 80);
        chk("p8 frame_done", 32'(frame_done), 1);
        chk("p8 done state", 32'(state_dbg), S_DONE);
        chk("p8 done edge", 32'(edge_count), 0);
        chk("p8 done samp", 32'(samp_en), 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_quiet($sformatf("p8 after done %0d", i));
            chk("p8 still done", 32'(state_dbg), S_DONE);
        end

        // P=5 odd prescale, 2-bit frame
        Enable = 1'b0;
        tick();
        chk_quiet("p5 idle");
        Enable = 1'b1; Prescale = 6'd5; Frame_Bits = 4'd2;
        tick();
        run_bits(5, 2, 0, 10);
        chk("p5 frame_done", 32'(frame_done), 1);

        // Restart mid-frame with P=16
        Prescale = 6'd16; Frame_Bits = 4'd10; Restart = 1'b1;
        tick();
        Restart = 1'b0;
        run_bits(16, 10, 0, 54);
        chk("p16 pre edge", 32'(edge_count), 6);
        chk("p16 pre bit", 32'(bit_count), 3);
        Restart = 1'b1;
        tick();
        Restart = 1'b0;
        run_bits(16, 10, 0, 160);
        chk("p16 frame_done", 32'(frame_done), 1);
        tick();
        chk("p16 done pulse end", 32'(frame_done), 0);

        // Illegal prescale
        Enable = 1'b0;
        tick();
        Enable = 1'b1; Prescale = 6'd3;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("err flag", 32'(prescale_err), 1);
            chk("err state", 32'(state_dbg), S_ERR);
            chk_quiet($sformatf("err %0d", i));
            tick();
        end
        Prescale = 6'd8; Restart = 1'b1;
        tick();
        Restart = 1'b0;
        chk("err cleared", 32'(prescale_err), 0);
        run_bits(8, 10, 0, 37);

        // Enable drop at bit 4
        chk("drop pre bit", 32'(bit_count), 4);
        Enable = 1'b0;
        tick();
        chk_quiet("drop");
        chk("drop err", 32'(prescale_err), 0);
        chk("drop state", 32'(state_dbg), S_IDLE);
        Enable = 1'b1;
        tick();
        Prescale = 6'd12;
        run_bits(8, 10, 0, 20);

        // Async reset mid-frame
        #2 RST = 1'b0;
        #1;
        chk_quiet("async rst");
        chk("async rst state", 32'(state_dbg), S_IDLE);
        Prescale = 6'd8;
        #1 RST = 1'b1;
        tick();
        run_bits(8, 10, 0, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
